// File: rtl/pio_gpio_edge.sv
// pio_gpio_edge: Avalon-MM GPIO slave with per-bit direction, set/clear
// writes, synchronised inputs, edge capture and a maskable level interrupt.
module pio_gpio_edge #(
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_OUT   = '0,
   parameter logic [WIDTH-1:0]  RESET_DIR   = '0,
   parameter int                EDGE_TYPE   = 0,
   parameter int                SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_DIR     = 3'd1;
   localparam logic [2:0] A_IRQMASK = 3'd2;
   localparam logic [2:0] A_EDGECAP = 3'd3;
   localparam logic [2:0] A_OUTSET  = 3'd4;
   localparam logic [2:0] A_OUTCLR  = 3'd5;

   logic                            wr_en;
   logic [WIDTH-1:0]                wdata;
   logic [WIDTH-1:0]                data_out_q, data_out_d;
   logic [WIDTH-1:0]                dir_q, dir_d;
   logic [WIDTH-1:0]                mask_q, mask_d;
   logic [WIDTH-1:0]                ecap_q, ecap_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                dly_q, dly_d;
   logic [WIDTH-1:0]                sync_out;
   logic [WIDTH-1:0]                rise, fall, edge_det;
   logic [WIDTH-1:0]                rd_bits;

   assign wr_en    = chipselect & ~write_n;
   assign wdata    = writedata[WIDTH-1:0];
   assign sync_out = sync_q[SYNC_STAGES-1];

   // Upper write-data bits carry nothing for narrow configurations.
   generate
      if (WIDTH < 32) begin : g_unused
         logic unused_wdata_hi;
         assign unused_wdata_hi = ^writedata[31:WIDTH];
      end
   endgenerate

   // Edge detection between the synchroniser output and its one-cycle delay.
   always_comb begin
      rise = sync_out & ~dly_q;
      fall = ~sync_out & dly_q;
      case (EDGE_TYPE)
         0:       edge_det = rise;
         1:       edge_det = fall;
         default: edge_det = rise | fall;
      endcase
   end

   // Next-state for the synchroniser chain and all bus-visible registers.
   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      dly_d      = sync_out;
      data_out_d = data_out_q;
      dir_d      = dir_q;
      mask_d     = mask_q;
      ecap_d     = ecap_q;
      if (wr_en) begin
         case (address)
            A_DATA:    data_out_d = wdata;
            A_DIR:     dir_d      = wdata;
            A_IRQMASK: mask_d     = wdata;
            A_EDGECAP: ecap_d     = ecap_q & ~wdata;
            A_OUTSET:  data_out_d = data_out_q | wdata;
            A_OUTCLR:  data_out_d = data_out_q & ~wdata;
            default:   ;
         endcase
      end
      // A new edge overrides a simultaneous clear on the same bit.
      ecap_d = ecap_d | edge_det;
   end

   // State registers; reset discards captured edges and empties the synchroniser.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out_q <= RESET_OUT;
         dir_q      <= RESET_DIR;
         mask_q     <= '0;
         ecap_q     <= '0;
         sync_q     <= '0;
         dly_q      <= '0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         ecap_q     <= ecap_d;
         sync_q     <= sync_d;
         dly_q      <= dly_d;
      end
   end

   // Zero-wait-state read mux; upper bits always read as zero.
   always_comb begin
      rd_bits = '0;
      case (address)
         A_DATA:    rd_bits = (data_out_q & dir_q) | (sync_out & ~dir_q);
         A_DIR:     rd_bits = dir_q;
         A_IRQMASK: rd_bits = mask_q;
         A_EDGECAP: rd_bits = ecap_q;
         default:   rd_bits = '0;
      endcase
      readdata = '0;
      readdata[WIDTH-1:0] = rd_bits;
   end

   assign out_port = data_out_q;
   assign oe       = dir_q;
   assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_edge.sv
// Scoreboard bench for pio_gpio_edge: stimulus queues expectations, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_pio_gpio_edge;

   localparam int W = 8;
   localparam int TIMEOUT_CYC = 2000;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [2:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic [W-1:0] in_port;
   logic [W-1:0] out_port;
   logic [W-1:0] oe;
   logic         irq;
   logic         done = 1'b0;

   pio_gpio_edge #(
      .WIDTH(W), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF),
      .EDGE_TYPE(0), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
   );

   always #5 clk = ~clk;

   localparam int S_OUT = 0, S_OE = 1, S_IRQ = 2, S_RD = 3;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         chk_t        c;
         logic [31:0] act;
         c = sb.pop_front();
         case (c.sel)
            S_OUT:   act = {24'h0, out_port};
            S_OE:    act = {24'h0, oe};
            S_IRQ:   act = {31'h0, irq};
            default: act = readdata;
         endcase
         n_vec++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
         end
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      while (!done && cyc < TIMEOUT_CYC) begin
         @(posedge clk);
         cyc++;
      end
      if (!done) begin
         n_fail++;
         $display("FAIL timeout: stimulus not finished after %0d cycles", TIMEOUT_CYC);
         $display("== %0d vectors applied, %0d miscompares == FAIL", n_vec, n_fail);
         $finish;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input int sel, input logic [31:0] exp, input string name);
      chk_t c;
      c.sel = sel; c.exp = exp; c.name = name;
      sb.push_back(c);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      chk(S_RD, exp, name);
      tick();
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      tick(2);
      reset_n = 1'b1;

      n_vec++;
      if (out_port !== 8'hA5 || oe !== 8'hFF || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_direct: out_port=%h oe=%h irq=%b", out_port, oe, irq);
      end

      chk(S_OUT, 32'hA5, "rst_out");
      chk(S_OE,  32'hFF, "rst_oe");
      chk(S_IRQ, 32'h0,  "rst_irq");
      rd(3'd2, 32'h0,  "rst_mask");
      rd(3'd3, 32'h0,  "rst_ecap");
      rd(3'd0, 32'hA5, "rst_data");

      wr(3'd0, 32'h0F);                 chk(S_OUT, 32'h0F, "data_wr");
      wr(3'd4, 32'hFFFF_FF30);          chk(S_OUT, 32'h3F, "outset");
      wr(3'd5, 32'h05);                 chk(S_OUT, 32'h3A, "outclr");
      rd(3'd4, 32'h0, "rd_outset");
      rd(3'd5, 32'h0, "rd_outclr");
      wr(3'd6, 32'hFF);                 chk(S_OUT, 32'h3A, "wr6_ignored");
      rd(3'd6, 32'h0, "rd6");

      wr(3'd1, 32'h0F);                 chk(S_OE, 32'h0F, "dir_wr");
      rd(3'd1, 32'h0F, "rd_dir");
      in_port = 8'hC0;
      tick();
      rd(3'd0, 32'h0A, "data_lag1");
      rd(3'd0, 32'hCA, "data_mixed");
      rd(3'd3, 32'hC0, "ecap_unmasked");
      chk(S_IRQ, 32'h0, "irq_unmasked");
      wr(3'd3, 32'hFF);
      rd(3'd3, 32'h0, "ecap_clr_all");

      in_port = 8'h00;
      tick(4);
      wr(3'd2, 32'h80);
      rd(3'd2, 32'h80, "rd_mask");
      in_port = 8'h80;
      tick(); chk(S_IRQ, 32'h0, "irq_lat1");
      tick(); chk(S_IRQ, 32'h0, "irq_lat2");
      tick(); chk(S_IRQ, 32'h1, "irq_lat3");
      rd(3'd3, 32'h80, "ecap_b7");
      wr(3'd3, 32'h80);                 chk(S_IRQ, 32'h0, "irq_cleared");
      rd(3'd3, 32'h0, "ecap_b7_clr");

      wr(3'd2, 32'h00);
      in_port = 8'h81;
      tick(3);
      rd(3'd3, 32'h01, "ecap_b0");
      in_port = 8'h85;
      tick(2);
      wr(3'd3, 32'h05);
      rd(3'd3, 32'h04, "set_wins");
      chk(S_IRQ, 32'h0, "irq_mask0");
      wr(3'd2, 32'h04);                 chk(S_IRQ, 32'h1, "irq_late_mask");

      in_port = 8'h00;
      tick(4);
      in_port = 8'hFF;
      tick(3);
      wr(3'd2, 32'hFF);                 chk(S_IRQ, 32'h1, "irq_all");
      rd(3'd3, 32'hFF, "ecap_full");
      reset_n = 1'b0; address = 3'd0; writedata = 32'h00;
      chipselect = 1'b1; write_n = 1'b0;
      tick();
      reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      chk(S_OUT, 32'hA5, "rst2_out");
      chk(S_OE,  32'hFF, "rst2_oe");
      chk(S_IRQ, 32'h0,  "rst2_irq");
      rd(3'd3, 32'h0,  "rst2_ecap0");
      rd(3'd2, 32'h0,  "rst2_mask");
      rd(3'd3, 32'h0,  "rst2_ecap2");
      rd(3'd3, 32'hFF, "rst2_refill");

      tick(2);
      done = 1'b1;
      if (n_fail == 0)
         $display("== %0d vectors applied, %0d miscompares == PASS", n_vec, n_fail);
      else
         $display("== %0d vectors applied, %0d miscompares == FAIL", n_vec, n_fail);
      $finish;
   end

endmodule
